// File: rtl/s4_pool_writer.sv
// -----------------------------------------------------------------------------
// s4_pool_writer
//
// Purpose:
//   Takes the C3 convolution output stream (CH channels in parallel, one
//   IN_DIM x IN_DIM map per channel, row-major) and applies 2x2 stride-2 max
//   pooling per channel. Each pooled pixel, with all channels packed into one
//   word, is written to the F4 feature-map memory at
//   BASE_ADDR + (row/2)*(IN_DIM/2) + (col/2).
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle pulse starting a frame (ignored while busy)
//   c3_valid  in   input pixel valid
//   c3_ready  out  high while a frame is running; transfer = valid && ready
//   c3_data   in   CH*DW packed pixels, channel k at [DW*k +: DW]
//   f4_wr_en  out  one-cycle F4 write strobe
//   f4_waddr  out  F4 write address (held between writes)
//   f4_wdata  out  CH*DW packed pooled pixels (held between writes)
//   busy      out  frame in progress
//   done      out  one-cycle pulse together with the final write of a frame
//
// Build option:
//   S4_POOL_RELU_EN  when defined, negative pooled results are written as 0.
// -----------------------------------------------------------------------------
module s4_pool_writer #(
    parameter int DW        = 16,
    parameter int CH        = 16,
    parameter int IN_DIM    = 10,
    parameter int AW        = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              c3_valid,
    output logic              c3_ready,
    input  logic [CH*DW-1:0]  c3_data,
    output logic              f4_wr_en,
    output logic [AW-1:0]     f4_waddr,
    output logic [CH*DW-1:0]  f4_wdata,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(IN_DIM);
    localparam int LN = IN_DIM / 2;
    localparam int LW = $clog2(LN);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DW-1:0] act(input logic signed [DW-1:0] v);
`ifdef S4_POOL_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    logic [0:0]             state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [CW-1:0]          row_q, row_d;
    logic signed [DW-1:0]   hold_q [CH];
    logic signed [DW-1:0]   lbuf_q [LN][CH];
    logic                   wr_en_q;
    logic [AW-1:0]          waddr_q;
    logic [CH*DW-1:0]       wdata_q;
    logic                   done_q;

    logic                   xfer;
    logic                   wr_fire;
    logic                   col_last;
    logic                   row_last;
    logic [LW-1:0]          lidx;
    logic [AW-1:0]          out_cnt;
    logic signed [DW-1:0]   pix  [CH];
    logic signed [DW-1:0]   pmax [CH];
    logic [CH*DW-1:0]       res_bus;

    assign c3_ready = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN);
    assign f4_wr_en = wr_en_q;
    assign f4_waddr = waddr_q;
    assign f4_wdata = wdata_q;
    assign done     = done_q;

    assign xfer     = (state_q == S_RUN) && c3_valid;
    assign col_last = (col_q == CW'(IN_DIM - 1));
    assign row_last = (row_q == CW'(IN_DIM - 1));
    // A pooled pixel completes on the bottom-right pixel of its 2x2 window.
    assign wr_fire  = xfer && col_q[0] && row_q[0];
    assign lidx     = col_q[LW:1];
    assign out_cnt  = AW'(row_q[CW-1:1]) * AW'(LN) + AW'(col_q[CW-1:1]);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (c3_valid) begin
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Horizontal max of the pixel pair, then vertical max against the pair
    // stored from the even row above.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            pix[k]                = $signed(c3_data[k*DW +: DW]);
            pmax[k]               = smax(hold_q[k], pix[k]);
            res_bus[k*DW +: DW]   = act(smax(lbuf_q[lidx][k], pmax[k]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                hold_q[k] <= '0;
                for (int e = 0; e < LN; e++) begin
                    lbuf_q[e][k] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wr_en_q <= wr_fire;
            done_q  <= wr_fire && (out_cnt == AW'(LN * LN - 1));
            if (wr_fire) begin
                waddr_q <= AW'(BASE_ADDR) + out_cnt;
                wdata_q <= res_bus;
            end
            if (xfer) begin
                for (int k = 0; k < CH; k++) begin
                    if (!col_q[0]) begin
                        hold_q[k] <= pix[k];
                    end else if (!row_q[0]) begin
                        lbuf_q[lidx][k] <= pmax[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_s4_pool_writer.sv
// -----------------------------------------------------------------------------
// tb_s4_pool_writer
//
// Self-checking bench for s4_pool_writer. Frames are built as arrays of
// packed pixels; the expected pooled memory image is computed directly from
// the 2x2 window maxima. A negedge monitor follows a transaction-level model
// of the frame (pixel index -> row/col -> expected write) and checks every
// output every cycle.
// -----------------------------------------------------------------------------
module tb_s4_pool_writer;

    localparam int DW = 16;
    localparam int CH = 16;
    localparam int AW = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              c3_valid = 1'b0;
    logic [CH*DW-1:0]  c3_data = '0;
    logic              c3_ready;
    logic              f4_wr_en;
    logic [AW-1:0]     f4_waddr;
    logic [CH*DW-1:0]  f4_wdata;
    logic              busy;
    logic              done;

    s4_pool_writer #(
        .DW(DW), .CH(CH), .IN_DIM(10), .AW(AW), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .c3_valid(c3_valid), .c3_ready(c3_ready), .c3_data(c3_data),
        .f4_wr_en(f4_wr_en), .f4_waddr(f4_waddr), .f4_wdata(f4_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [255:0] frame   [100];
    logic [255:0] exp_mem [25];
    logic [255:0] got_mem [25];

    // Expected image: max over each 2x2 window, per channel, signed.
    task automatic build_exp();
        logic signed [15:0] m;
        logic signed [15:0] v;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                for (int k = 0; k < CH; k++) begin
                    m = frame[20*r + 2*c][k*16 +: 16];
                    for (int dy = 0; dy < 2; dy++) begin
                        for (int dx = 0; dx < 2; dx++) begin
                            v = frame[(2*r+dy)*10 + 2*c + dx][k*16 +: 16];
                            if (v > m) m = v;
                        end
                    end
`ifdef S4_POOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    exp_mem[r*5 + c][k*16 +: 16] = m;
                end
            end
        end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 100; i++)
            for (int k = 0; k < CH; k++)
                frame[i][k*16 +: 16] = 16'(i);
    endtask

    task automatic set_rand();
        for (int i = 0; i < 100; i++)
            for (int k = 0; k < CH; k++)
                frame[i][k*16 +: 16] = 16'($urandom);
    endtask

    task automatic set_neg();
        set_rand();
        for (int i = 0; i < 100; i++)
            frame[i][3*16 +: 16] = (i == 1) ? 16'hFFFD : 16'hFFFB;
    endtask

    task automatic set_const();
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < CH-1; k++)
                frame[i][k*16 +: 16] = 16'(k*100);
            frame[i][15*16 +: 16] = 16'h8000;
        end
    endtask

    // Monitor model state
    bit           m_run = 1'b0;
    int           n_pix = 0;
    bit           pend = 1'b0;
    int           pend_addr = 0;
    int           wr_count = 0;
    logic [6:0]   last_addr = '0;
    logic [255:0] last_data = '0;
    int           mr, mc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_run     = 1'b0;
            n_pix     = 0;
            pend      = 1'b0;
            last_addr = '0;
            last_data = '0;
        end else begin
            check("ready", 256'(c3_ready), 256'(m_run));
            check("busy", 256'(busy), 256'(m_run));
            check("wr_en", 256'(f4_wr_en), 256'(pend));
            if (f4_wr_en) begin
                wr_count++;
                if (f4_waddr < 7'd25) got_mem[f4_waddr] = f4_wdata;
            end
            if (pend) begin
                check("waddr", 256'(f4_waddr), 256'(pend_addr));
                check("wdata", f4_wdata, exp_mem[pend_addr]);
                check("done", 256'(done), 256'(pend_addr == 24));
                last_addr = 7'(pend_addr);
                last_data = exp_mem[pend_addr];
            end else begin
                check("done_low", 256'(done), 256'(0));
                check("waddr_hold", 256'(f4_waddr), 256'(last_addr));
                check("wdata_hold", f4_wdata, last_data);
            end
            // Predict the next cycle from the frame rules.
            pend = 1'b0;
            if (m_run && c3_valid) begin
                mr = n_pix / 10;
                mc = n_pix % 10;
                if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                    pend      = 1'b1;
                    pend_addr = (mr / 2) * 5 + (mc / 2);
                end
                n_pix++;
                if (n_pix == 100) m_run = 1'b0;
            end else if (!m_run && start) begin
                m_run = 1'b1;
                n_pix = 0;
            end
        end
    end

    // All drive tasks are entered and left 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int npix, input bit gap, input bit mid, input bit chain);
        for (int i = 0; i < npix; i++) begin
            if (gap) begin
                for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
                    c3_valid = 1'b0;
                    start    = 1'b0;
                    c3_data  = {8{$urandom}};
                    @(posedge clk); #1;
                end
            end
            c3_valid = 1'b1;
            c3_data  = frame[i];
            start    = mid && (i == 40);
            @(posedge clk); #1;
        end
        c3_valid = 1'b0;
        start    = chain;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit gap, input bit mid);
        int base;
        build_exp();
        base = wr_count;
        pulse_start();
        feed(100, gap, mid, 1'b0);
        check(tag, 256'(wr_count - base), 256'(25));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"}, 256'(f4_wr_en), 256'(0));
        check({tag, "_waddr"}, 256'(f4_waddr), 256'(0));
        check({tag, "_wdata"}, f4_wdata, 256'(0));
        check({tag, "_done"}, 256'(done), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_ready"}, 256'(c3_ready), 256'(0));
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // c3_valid while idle must be ignored
        c3_valid = 1'b1;
        c3_data  = {8{$urandom}};
        repeat (5) @(posedge clk);
        #1;
        c3_valid = 1'b0;
        check("idle_no_writes", 256'(wr_count), 256'(0));

        // Ramp frame
        set_ramp();
        run_frame("ramp_count", 1'b0, 1'b0);
        check("ramp_addr0", 256'(got_mem[0][15:0]), 256'(11));
        check("ramp_addr24", 256'(got_mem[24][255:240]), 256'(99));
        check("ramp_addr7", 256'(got_mem[7][127:112]), 256'(35));

        // Negative window in channel 3
        set_neg();
        run_frame("neg_count", 1'b0, 1'b0);
`ifdef S4_POOL_RELU_EN
        check("neg_addr0_ch3", 256'(got_mem[0][63:48]), 256'(16'h0000));
        check("neg_addr13_ch3", 256'(got_mem[13][63:48]), 256'(16'h0000));
`else
        check("neg_addr0_ch3", 256'(got_mem[0][63:48]), 256'(16'hFFFD));
        check("neg_addr13_ch3", 256'(got_mem[13][63:48]), 256'(16'hFFFB));
`endif

        // Channel independence
        set_const();
        run_frame("const_count", 1'b0, 1'b0);
        check("const_ch1", 256'(got_mem[7][31:16]), 256'(100));
        check("const_ch14", 256'(got_mem[18][239:224]), 256'(1400));
`ifdef S4_POOL_RELU_EN
        check("const_ch15", 256'(got_mem[12][255:240]), 256'(16'h0000));
`else
        check("const_ch15", 256'(got_mem[12][255:240]), 256'(16'h8000));
`endif

        // Gapped ramp frame
        set_ramp();
        run_frame("gap_count", 1'b1, 1'b0);

        // Random data, start pulsed mid-frame
        set_rand();
        run_frame("midstart_count", 1'b1, 1'b1);

        // Start in the done cycle chains a second frame
        set_rand();
        build_exp();
        base = wr_count;
        pulse_start();
        feed(100, 1'b0, 1'b0, 1'b1);
        check("chain_first_count", 256'(wr_count - base), 256'(25));
        set_rand();
        build_exp();
        base = wr_count;
        feed(100, 1'b1, 1'b0, 1'b0);
        check("chain_second_count", 256'(wr_count - base), 256'(25));

        // Reset after 47 transfers
        set_ramp();
        build_exp();
        base = wr_count;
        pulse_start();
        feed(47, 1'b0, 1'b0, 1'b0);
        check("partial_count", 256'(wr_count - base), 256'(10));
        #1 rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("held_rst");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_no_writes", 256'(wr_count - base), 256'(10));
        set_ramp();
        run_frame("post_rst_count", 1'b0, 1'b0);
        check("post_rst_addr0", 256'(got_mem[0][15:0]), 256'(11));
        check("post_rst_addr24", 256'(got_mem[24][15:0]), 256'(99));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
